nx_node_instr_store: RTL and testbench

- Responder end of the node instruction-fetch interface; serves the core's fetch reads from a node-local instruction RAM.
- Also accepts instruction words from the node's inbound loader stream and appends them.
- Tracks the populated count, which drives the core's populated input.
- Arbitrates a single-port RAM between loader writes and fetch reads, and signals unserviced reads via stall.

---
 rtl/nx_node_instr_store_pkg.sv | 11 +
 rtl/nx_ram_sp.sv | 43 ++++
 rtl/nx_node_instr_store.sv | 95 +++++++++
 tb/tb_nx_node_instr_store.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nx_node_instr_store_pkg.sv
// Node-wide constants for the instruction path.
// Shared by the instruction store and the node core.
package nx_node_instr_store_pkg;

    localparam int NODE_PARAM_WIDTH   = 16;
    localparam int NODE_INSTR_DEPTH_W = 10;
    localparam int INSTR_W            = 32;

    typedef logic [INSTR_W-1:0] instruction_t;

endpackage

// File: rtl/nx_ram_sp.sv
// Generic single-port synchronous RAM with a 1-cycle registered read.
// The read register holds its value while no read is issued.
module nx_ram_sp #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_addr] <= i_wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (i_rd_en) begin
            rd_data_d = mem[i_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/nx_node_instr_store.sv
// Node instruction store: serves core fetches and appends loader words,
// sharing one single-port RAM with alternating priority under contention.
module nx_node_instr_store #(
    parameter int RAM_ADDR_W       = nx_node_instr_store_pkg::NODE_INSTR_DEPTH_W,
    parameter int RAM_DATA_W       = nx_node_instr_store_pkg::INSTR_W,
    parameter int NODE_PARAM_WIDTH = nx_node_instr_store_pkg::NODE_PARAM_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [RAM_ADDR_W-1:0]       i_instr_addr,
    input  logic                        i_instr_rd_en,
    output logic [RAM_DATA_W-1:0]       o_instr_rd_data,
    output logic                        o_instr_stall,
    input  logic                        i_load_valid,
    input  logic [RAM_DATA_W-1:0]       i_load_data,
    output logic                        o_load_ready,
    input  logic                        i_clear,
    output logic [NODE_PARAM_WIDTH-1:0] o_populated,
    output logic                        o_full
);

    logic [RAM_ADDR_W:0]   wr_ptr_q;
    logic [RAM_ADDR_W:0]   wr_ptr_d;
    logic                  fetch_lost_q;
    logic                  fetch_lost_d;
    logic                  load_lost_q;
    logic                  load_lost_d;
    logic                  rd_zero_q;
    logic                  rd_zero_d;

    logic                  full;
    logic                  load_pend;
    logic                  rd_grant;
    logic                  load_acc;
    logic                  rd_hit;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [RAM_DATA_W-1:0] ram_rd_data;

    // A read only yields to a load that already lost the previous cycle.
    always_comb begin
        full         = wr_ptr_q[RAM_ADDR_W];
        load_pend    = i_load_valid && !full && !i_clear;
        rd_grant     = i_instr_rd_en &&
                       !(load_pend && load_lost_q && !fetch_lost_q);
        o_load_ready = !full && !i_clear && !rd_grant;
        load_acc     = i_load_valid && o_load_ready;
        rd_hit       = rd_grant && ({1'b0, i_instr_addr} < wr_ptr_q);
        ram_addr     = load_acc ? wr_ptr_q[RAM_ADDR_W-1:0] : i_instr_addr;

        wr_ptr_d = wr_ptr_q;
        if (i_clear) begin
            wr_ptr_d = '0;
        end else if (load_acc) begin
            wr_ptr_d = wr_ptr_q + (RAM_ADDR_W+1)'(1);
        end

        fetch_lost_d = i_instr_rd_en && !rd_grant;
        load_lost_d  = load_pend && rd_grant;
        rd_zero_d    = rd_grant ? !rd_hit : rd_zero_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q     <= '0;
            fetch_lost_q <= 1'b0;
            load_lost_q  <= 1'b0;
            rd_zero_q    <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fetch_lost_q <= fetch_lost_d;
            load_lost_q  <= load_lost_d;
            rd_zero_q    <= rd_zero_d;
        end
    end

    nx_ram_sp #(
        .ADDR_W (RAM_ADDR_W),
        .DATA_W (RAM_DATA_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_addr    (ram_addr),
        .i_wr_en   (load_acc),
        .i_wr_data (i_load_data),
        .i_rd_en   (rd_hit),
        .o_rd_data (ram_rd_data)
    );

    // Reads beyond the populated range return zero, not stale RAM.
    assign o_instr_rd_data = rd_zero_q ? '0 : ram_rd_data;
    assign o_instr_stall   = fetch_lost_q;
    assign o_populated     = NODE_PARAM_WIDTH'(wr_ptr_q);
    assign o_full          = full;

endmodule

// File: tb/tb_nx_node_instr_store.sv
// Directed bench for nx_node_instr_store: a table of per-cycle vectors on a
// 1024-deep store plus hand sequences for full, clear and async reset.
module tb_nx_node_instr_store;

    logic        clk;
    logic        rst_n;

    logic [9:0]  a_addr;
    logic        a_rd;
    logic [31:0] a_data;
    logic        a_stall;
    logic        a_lv;
    logic [31:0] a_ld;
    logic        a_rdy;
    logic        a_clr;
    logic [15:0] a_pop;
    logic        a_full;

    logic [1:0]  b_addr;
    logic        b_rd;
    logic [31:0] b_data;
    logic        b_stall;
    logic        b_lv;
    logic [31:0] b_ld;
    logic        b_rdy;
    logic        b_clr;
    logic [15:0] b_pop;
    logic        b_full;

    int total;
    int bad;

    nx_node_instr_store #(
        .RAM_ADDR_W       (10),
        .RAM_DATA_W       (32),
        .NODE_PARAM_WIDTH (16)
    ) dut_a (
        .i_clk           (clk),
        .i_rst           (rst_n),
        .i_instr_addr    (a_addr),
        .i_instr_rd_en   (a_rd),
        .o_instr_rd_data (a_data),
        .o_instr_stall   (a_stall),
        .i_load_valid    (a_lv),
        .i_load_data     (a_ld),
        .o_load_ready    (a_rdy),
        .i_clear         (a_clr),
        .o_populated     (a_pop),
        .o_full          (a_full)
    );

    nx_node_instr_store #(
        .RAM_ADDR_W       (2),
        .RAM_DATA_W       (32),
        .NODE_PARAM_WIDTH (16)
    ) dut_b (
        .i_clk           (clk),
        .i_rst           (rst_n),
        .i_instr_addr    (b_addr),
        .i_instr_rd_en   (b_rd),
        .o_instr_rd_data (b_data),
        .o_instr_stall   (b_stall),
        .i_load_valid    (b_lv),
        .i_load_data     (b_ld),
        .o_load_ready    (b_rdy),
        .i_clear         (b_clr),
        .o_populated     (b_pop),
        .o_full          (b_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rd;
        logic [9:0]  addr;
        logic        lv;
        logic [31:0] ld;
        logic        clr;
        logic        e_rdy;
        logic [31:0] e_data;
        logic        e_stall;
        logic [15:0] e_pop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic [9:0] addr, logic lv,
                                logic [31:0] ld, logic clr, logic e_rdy,
                                logic [31:0] e_data, logic e_stall,
                                logic [15:0] e_pop);
        vec_t v;
        v.rd = rd; v.addr = addr; v.lv = lv; v.ld = ld; v.clr = clr;
        v.e_rdy = e_rdy; v.e_data = e_data;
        v.e_stall = e_stall; v.e_pop = e_pop;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a_addr = '0; a_rd = 0; a_lv = 0; a_ld = '0; a_clr = 0;
        b_addr = '0; b_rd = 0; b_lv = 0; b_ld = '0; b_clr = 0;

        // rd addr lv ld clr | rdy data stall pop  (outputs seen this cycle)
        vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 32'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA1, 0, 1, 32'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hB2, 0, 1, 32'h00, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'hC3, 0, 1, 32'h00, 0, 2));
        vecs.push_back(mk(1, 0, 0, 32'h00, 0, 0, 32'h00, 0, 3));
        vecs.push_back(mk(1, 1, 0, 32'h00, 0, 0, 32'hA1, 0, 3));
        vecs.push_back(mk(1, 2, 0, 32'h00, 0, 0, 32'hB2, 0, 3));
        vecs.push_back(mk(1, 5, 0, 32'h00, 0, 0, 32'hC3, 0, 3));
        vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 32'h00, 0, 3));
        vecs.push_back(mk(1, 0, 1, 32'hD4, 0, 0, 32'h00, 0, 3));
        vecs.push_back(mk(1, 0, 1, 32'hD4, 0, 1, 32'hA1, 0, 3));
        vecs.push_back(mk(1, 0, 1, 32'hE5, 0, 0, 32'hA1, 1, 4));
        vecs.push_back(mk(1, 0, 1, 32'hE5, 0, 1, 32'hA1, 0, 4));
        vecs.push_back(mk(1, 0, 1, 32'hF6, 0, 0, 32'hA1, 1, 5));
        vecs.push_back(mk(1, 0, 1, 32'hF6, 0, 1, 32'hA1, 0, 5));
        vecs.push_back(mk(1, 0, 1, 32'h17, 0, 0, 32'hA1, 1, 6));
        vecs.push_back(mk(1, 0, 1, 32'h17, 0, 1, 32'hA1, 0, 6));
        vecs.push_back(mk(1, 6, 0, 32'h00, 0, 0, 32'hA1, 1, 7));
        vecs.push_back(mk(1, 3, 0, 32'h00, 0, 0, 32'h17, 0, 7));
        vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 32'hD4, 0, 7));
        vecs.push_back(mk(1, 0, 1, 32'h99, 1, 0, 32'hD4, 0, 7));
        vecs.push_back(mk(1, 0, 0, 32'h00, 0, 0, 32'hA1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 32'h00, 0, 0));

        #1;
        chk("rst_data", a_data, 32'h0);
        chk("rst_pop", a_pop, 16'd0);
        chk("rst_full", a_full, 1'b0);
        chk("rst_stall", a_stall, 1'b0);
        chk("rst_rdy", a_rdy, 1'b1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_rd = vecs[i].rd; a_addr = vecs[i].addr;
            a_lv = vecs[i].lv; a_ld = vecs[i].ld; a_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_rdy", i), a_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d_data", i), a_data, vecs[i].e_data);
            chk($sformatf("v%0d_stall", i), a_stall, vecs[i].e_stall);
            chk($sformatf("v%0d_pop", i), a_pop, vecs[i].e_pop);
            chk($sformatf("v%0d_full", i), a_full, 1'b0);
        end
        @(negedge clk);
        a_rd = 0; a_lv = 0; a_clr = 0;

        // Fill the 4-deep store, then offer a fifth word
        for (int i = 0; i < 4; i++) begin
            b_lv = 1'b1;
            b_ld = 32'h11 * (i + 1);
            #1;
            chk($sformatf("b_fill%0d_rdy", i), b_rdy, 1'b1);
            @(negedge clk);
        end
        b_ld = 32'h55;
        #1;
        chk("b_full", b_full, 1'b1);
        chk("b_full_rdy", b_rdy, 1'b0);
        chk("b_full_pop", b_pop, 16'd4);
        @(negedge clk);
        #1;
        chk("b_full_pop_hold", b_pop, 16'd4);
        @(negedge clk);
        b_lv = 1'b0; b_rd = 1'b1; b_addr = 2'd3;
        @(negedge clk);
        b_addr = 2'd0;
        #1;
        chk("b_rd3", b_data, 32'h44);
        chk("b_rd3_stall", b_stall, 1'b0);
        @(negedge clk);
        b_rd = 1'b0;
        #1;
        chk("b_rd0_nowrap", b_data, 32'h11);

        // Async reset mid-load and mid-fetch
        @(negedge clk);
        a_lv = 1'b1; a_ld = 32'h5A;
        @(negedge clk);
        a_ld = 32'h6B; a_rd = 1'b1; a_addr = 10'd0;
        #1;
        chk("r_pre_rdy", a_rdy, 1'b0);
        @(posedge clk);
        #2;
        chk("r_pre_data", a_data, 32'h5A);
        chk("r_pre_pop", a_pop, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("r_async_data", a_data, 32'h0);
        chk("r_async_pop", a_pop, 16'd0);
        chk("r_async_stall", a_stall, 1'b0);
        chk("r_async_b_pop", b_pop, 16'd0);
        chk("r_async_b_full", b_full, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a_rd = 1'b0; a_lv = 1'b1; a_ld = 32'h77;
        @(negedge clk);
        a_lv = 1'b0; a_rd = 1'b1; a_addr = 10'd0;
        #1;
        chk("r_post_pop", a_pop, 16'd1);
        chk("r_post_stall", a_stall, 1'b0);
        @(negedge clk);
        a_rd = 1'b0;
        #1;
        chk("r_post_data", a_data, 32'h77);
        chk("r_post_stall2", a_stall, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
